reorder_buffer: RTL
===================

# reorder_buffer

In-order retirement buffer sitting between rename and the RAT/architectural register file. It accepts up to FETCH_WIDTH renamed instructions per cycle and returns each one's ROB index as its physical source tag (`psrc`). It collects execution results from writeback ports and retires up to COMMIT_WIDTH completed instructions per cycle, in program order, on the retire interface consumed by the RAT.

## Interface
- FETCH_WIDTH, 2, allocation lanes per cycle
- COMMIT_WIDTH, 2, retire lanes per cycle
- WB_PORTS, 2, writeback ports
- ROB_DEPTH, 16, entries; power of two, ≥ 2×FETCH_WIDTH
- CTL_W, 32, width of opaque `control_t` payload
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  discard all entries (mispredict/exception)
- alloc_valid  in  FETCH_WIDTH  lane valid; set lanes contiguous from lane 0
- alloc_dst  in  FETCH_WIDTH×5  architectural destination (`creg_addr_t`)
- alloc_pc  in  FETCH_WIDTH×64  instruction PC
- alloc_ctl  in  FETCH_WIDTH×CTL_W  control payload
- alloc_ready  out  1  free entries ≥ FETCH_WIDTH
- psrc  out  FETCH_WIDTH×log2(ROB_DEPTH)  ROB index assigned to each lane (tail+i)
- wb_valid  in  WB_PORTS  result valid
- wb_idx  in  WB_PORTS×log2(ROB_DEPTH)  target entry
- wb_data  in  WB_PORTS×64  result
- retire_valid  out  COMMIT_WIDTH  lane retiring this cycle
- retire_data  out  COMMIT_WIDTH×64  result
- retire_dst  out  COMMIT_WIDTH×5  architectural destination
- retire_preg  out  COMMIT_WIDTH×log2(ROB_DEPTH)  retiring ROB index
- retire_ctl  out  COMMIT_WIDTH×CTL_W  control payload
- retire_pc  out  COMMIT_WIDTH×64  PC
- count  out  log2(ROB_DEPTH)+1  occupied entries

## Operation
- Circular buffer with a head pointer, a tail pointer and an occupancy count. Each entry holds valid, done, dst, pc, ctl and data.
- Allocation fires when `alloc_ready` is high and `alloc_valid[0]` is set. Lane i writes entry tail+i (mod ROB_DEPTH) with valid=1 and done=0. Tail advances by popcount(alloc_valid).
- `alloc_valid` must be contiguous from lane 0. A non-contiguous pattern is illegal; the bench asserts against it.
- `psrc[i]` = tail+i, combinational. It is valid regardless of `alloc_ready`.
- Writeback: each `wb_valid` port sets done=1 and data=wb_data on entry `wb_idx`.
  - Writeback to an entry with valid=0 is ignored.
  - Two ports targeting the same index in one cycle: the higher port number wins.
- Retire lane j is valid iff entry head+j is valid and done, and all lanes below j are valid.
  - The first incomplete entry stops retirement.
  - Retire outputs are combinational from entry state.
  - At the clock edge, retired entries are cleared (valid=0) and head advances by the retire count.
- Count update: count_next = count + allocated − retired. Allocation and retirement in the same cycle are both honoured.
- Full: count > ROB_DEPTH−FETCH_WIDTH drops `alloc_ready`. Empty: count = 0 forces all `retire_valid` low.
- Pointers wrap modulo ROB_DEPTH.
- `flush` has priority over allocation, writeback and retirement in the same cycle:
  - next state: all valid=0, head=tail=0, count=0;
  - retire outputs during the flush cycle are still driven combinationally, but the consumer must ignore them when `flush` is high.

## Timing
- Reset (resetn=0, asynchronous): head=tail=0, count=0, all entry valid/done=0. Outputs: `alloc_ready`=1, `retire_valid`=0, all retire data/dst/preg/ctl/pc=0, `psrc[i]`=i.
- Deassertion of `resetn` is synchronized outside this block. Reset mid-operation discards all in-flight entries.
- Allocation to earliest retirement: 1 cycle after the writeback edge (default build).
- Writeback is registered: done becomes visible the cycle after `wb_valid`.
- `alloc_ready` depends only on registered count; it has no combinational path from `alloc_valid`.

## Configuration
- `RVCPU_ROB_WB_BYPASS_EN` defined: a writeback hitting an entry in the head..head+COMMIT_WIDTH−1 window counts as done in the same cycle.
  - That entry retires in the writeback cycle, with `retire_data` taken from `wb_data`.
  - The in-order and stop-at-first-incomplete rules still apply.
- Undefined: retirement sees only registered done bits, one cycle later. The bypass mux is not built.

## Test plan
- Reset, then allocate 2 lanes (dst=5, dst=6): `psrc`=0,1; next cycle count=2 and `retire_valid`=00.
- Writeback idx1 before idx0: no retire. Writeback idx0 (data=0xAA): next cycle retire_valid=11 with retire_data=0xAA then idx1 data, retire_preg=0,1; count=0.
- Allocate continuously with no writeback: `alloc_ready` falls when count=15 (depth 16). Then allocate and retire 2 per cycle for 40 cycles: pointers wrap, indices go 14,15,0,1, count is constant.
- With 4 entries pending, assert flush together with alloc and wb: next cycle count=0, `psrc`=0,1, `retire_valid`=00.
- Writeback to a never-allocated index: no state change. Dual writeback to the same index with data 1 and 2: entry holds 2.
- With the bypass macro defined: writeback to head → `retire_valid[0]`=1 in the same cycle. Without it: one cycle later.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// Port bundle for reorder_buffer: rename-side allocation, writeback ports and the
// in-order retire interface to the RAT. master = rename/RAT side, slave = ROB.
interface reorder_buffer_if #(
  parameter int FETCH_WIDTH  = 2,
  parameter int COMMIT_WIDTH = 2,
  parameter int WB_PORTS     = 2,
  parameter int ROB_DEPTH    = 16,
  parameter int CTL_W        = 32
);
  localparam int PTR_W = $clog2(ROB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: allocation lanes fire on a clock edge where alloc_ready is high and
  // alloc_valid[0] is set; alloc_valid must be contiguous from lane 0. Retire lanes
  // have no ready: the consumer takes every retire_valid lane and ignores them
  // whenever flush is high. Writebacks are fire-and-forget.
  logic                                 flush;
  logic [FETCH_WIDTH-1:0]               alloc_valid;
  logic [FETCH_WIDTH-1:0][4:0]          alloc_dst;
  logic [FETCH_WIDTH-1:0][63:0]         alloc_pc;
  logic [FETCH_WIDTH-1:0][CTL_W-1:0]    alloc_ctl;
  logic                                 alloc_ready;
  logic [FETCH_WIDTH-1:0][PTR_W-1:0]    psrc;
  logic [WB_PORTS-1:0]                  wb_valid;
  logic [WB_PORTS-1:0][PTR_W-1:0]       wb_idx;
  logic [WB_PORTS-1:0][63:0]            wb_data;
  logic [COMMIT_WIDTH-1:0]              retire_valid;
  logic [COMMIT_WIDTH-1:0][63:0]        retire_data;
  logic [COMMIT_WIDTH-1:0][4:0]         retire_dst;
  logic [COMMIT_WIDTH-1:0][PTR_W-1:0]   retire_preg;
  logic [COMMIT_WIDTH-1:0][CTL_W-1:0]   retire_ctl;
  logic [COMMIT_WIDTH-1:0][63:0]        retire_pc;
  logic [CNT_W-1:0]                     count;

  modport master (
    output flush, alloc_valid, alloc_dst, alloc_pc, alloc_ctl,
    output wb_valid, wb_idx, wb_data,
    input  alloc_ready, psrc, count,
    input  retire_valid, retire_data, retire_dst, retire_preg, retire_ctl, retire_pc
  );

  modport slave (
    input  flush, alloc_valid, alloc_dst, alloc_pc, alloc_ctl,
    input  wb_valid, wb_idx, wb_data,
    output alloc_ready, psrc, count,
    output retire_valid, retire_data, retire_dst, retire_preg, retire_ctl, retire_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer between rename and the RAT. Optional same-cycle
// writeback-to-retire bypass is enabled by defining RVCPU_ROB_WB_BYPASS_EN.
module reorder_buffer #(
  parameter int FETCH_WIDTH  = 2,
  parameter int COMMIT_WIDTH = 2,
  parameter int WB_PORTS     = 2,
  parameter int ROB_DEPTH    = 16,
  parameter int CTL_W        = 32
) (
  input logic             clk,
  input logic             resetn,
  reorder_buffer_if.slave rob
);
  localparam int PTR_W = $clog2(ROB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ROB_DEPTH-1:0] ent_valid;
  logic [ROB_DEPTH-1:0] ent_done;
  logic [4:0]           ent_dst  [ROB_DEPTH];
  logic [63:0]          ent_pc   [ROB_DEPTH];
  logic [CTL_W-1:0]     ent_ctl  [ROB_DEPTH];
  logic [63:0]          ent_data [ROB_DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count_q;

  logic [FETCH_WIDTH-1:0][PTR_W-1:0]  alloc_idx;
  logic [COMMIT_WIDTH-1:0][PTR_W-1:0] ret_idx;
  logic                               alloc_fire;
  logic [CNT_W-1:0]                   n_alloc;
  logic [CNT_W-1:0]                   n_retire;
  logic [COMMIT_WIDTH-1:0]            ret_ok;
  logic [COMMIT_WIDTH-1:0]            eff_done;
  logic [COMMIT_WIDTH-1:0][63:0]      eff_data;

  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) alloc_idx[i] = tail + PTR_W'(i);
    for (int j = 0; j < COMMIT_WIDTH; j++) ret_idx[j] = head + PTR_W'(j);
  end

  // Ready comes from the registered count only, so it never depends on alloc_valid.
  assign rob.alloc_ready = (count_q <= CNT_W'(ROB_DEPTH - FETCH_WIDTH));
  assign alloc_fire      = rob.alloc_ready & rob.alloc_valid[0];
  assign rob.psrc        = alloc_idx;
  assign rob.count       = count_q;

  always_comb begin
    n_alloc = '0;
    if (alloc_fire) begin
      for (int i = 0; i < FETCH_WIDTH; i++)
        if (rob.alloc_valid[i]) n_alloc = n_alloc + CNT_W'(1);
    end
  end

  always_comb begin
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      eff_done[j] = ent_done[ret_idx[j]];
      eff_data[j] = ent_data[ret_idx[j]];
`ifdef RVCPU_ROB_WB_BYPASS_EN
      // Later ports override earlier ones, matching the registered writeback priority.
      for (int p = 0; p < WB_PORTS; p++) begin
        if (rob.wb_valid[p] && (rob.wb_idx[p] == ret_idx[j])) begin
          eff_done[j] = 1'b1;
          eff_data[j] = rob.wb_data[p];
        end
      end
`endif
    end
  end

  always_comb begin
    logic run;
    run      = 1'b1;
    n_retire = '0;
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      ret_ok[j] = run & ent_valid[ret_idx[j]] & eff_done[j];
      run       = ret_ok[j];
      if (ret_ok[j]) n_retire = n_retire + CNT_W'(1);
    end
  end

  // Payload is zeroed on idle lanes so reset and empty states present all-zero fields.
  always_comb begin
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      rob.retire_valid[j] = ret_ok[j];
      rob.retire_data[j]  = ret_ok[j] ? eff_data[j]          : '0;
      rob.retire_dst[j]   = ret_ok[j] ? ent_dst[ret_idx[j]]  : '0;
      rob.retire_preg[j]  = ret_ok[j] ? ret_idx[j]           : '0;
      rob.retire_ctl[j]   = ret_ok[j] ? ent_ctl[ret_idx[j]]  : '0;
      rob.retire_pc[j]    = ret_ok[j] ? ent_pc[ret_idx[j]]   : '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head      <= '0;
      tail      <= '0;
      count_q   <= '0;
      ent_valid <= '0;
      ent_done  <= '0;
    end else if (rob.flush) begin
      head      <= '0;
      tail      <= '0;
      count_q   <= '0;
      ent_valid <= '0;
      ent_done  <= '0;
    end else begin
      for (int p = 0; p < WB_PORTS; p++)
        if (rob.wb_valid[p] && ent_valid[rob.wb_idx[p]]) ent_done[rob.wb_idx[p]] <= 1'b1;
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (ret_ok[j]) begin
          ent_valid[ret_idx[j]] <= 1'b0;
          ent_done[ret_idx[j]]  <= 1'b0;
        end
      end
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (alloc_fire && rob.alloc_valid[i]) begin
          ent_valid[alloc_idx[i]] <= 1'b1;
          ent_done[alloc_idx[i]]  <= 1'b0;
        end
      end
      head    <= head + n_retire[PTR_W-1:0];
      tail    <= tail + n_alloc[PTR_W-1:0];
      count_q <= count_q + n_alloc - n_retire;
    end
  end

  // Payload storage needs no reset: it is only observed through valid entries.
  always_ff @(posedge clk) begin
    for (int p = 0; p < WB_PORTS; p++)
      if (rob.wb_valid[p] && ent_valid[rob.wb_idx[p]]) ent_data[rob.wb_idx[p]] <= rob.wb_data[p];
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (alloc_fire && rob.alloc_valid[i]) begin
        ent_dst[alloc_idx[i]] <= rob.alloc_dst[i];
        ent_pc[alloc_idx[i]]  <= rob.alloc_pc[i];
        ent_ctl[alloc_idx[i]] <= rob.alloc_ctl[i];
      end
    end
  end
endmodule
